// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an N-digit common-anode
// 7-segment display. A load strobe captures digit codes, decimal points and
// per-digit blanks into a shadow register. One digit is driven per refresh
// slot, and every slot opens with an all-anodes-off guard interval so the
// previous digit's pattern cannot ghost onto the next one.
//
// Optional feature: define SEVEN_SEG_BLINK_EN to build a frame counter and a
// blink phase. Digits whose captured blink_mask bit is set go dark during
// the odd blink phase. Without the macro, blink_mask is accepted but ignored.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seven_seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(REFRESH_DIV - 1);

  // Glyph table for a common-anode display: 0 = segment lit, order {g..a}.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b1000111;  // L
      4'hB:    seg = 7'b0000110;  // E
      4'hC:    seg = 7'b1000001;  // U
      4'hD:    seg = 7'b1001000;  // N
      4'hE:    seg = 7'b0111111;  // '-'
      default: seg = 7'b1111111;  // blank glyph
    endcase
    return seg;
  endfunction

  // Shadow register: the only copy of the display contents the scanner reads.
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;

  // Scan timing.
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             slot_end;
  logic             frame_end;
  logic             guard_active;

  // Registered outputs.
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  // Per-digit darkening from the blink feature (all zero without it).
  logic [NUM_DIGITS-1:0] blink_dark;

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] LAST_FRAME = FR_W'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] blink_mask_q, blink_mask_d;
  logic [FR_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                  phase_q, phase_d;

  // Blink timing: count whole frames; flip the phase each BLINK_FRAMES frames.
  always_comb begin
    blink_mask_d = load ? blink_mask : blink_mask_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;
    if (frame_end) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    blink_dark = phase_q ? blink_mask_q : '0;
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_mask_q <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      blink_mask_q <= blink_mask_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
    end
  end
`else
  // blink_mask is kept on the port for pin compatibility only.
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;

  // No blink hardware: nothing is ever darkened by the blink phase.
  always_comb begin
    blink_dark = '0;
  end
`endif

  // The guard comparison degenerates to a constant when the guard is
  // disabled, so it is only built when there is a guard to measure.
  generate
    if (GUARD_CYCLES > 0) begin : g_guard
      assign guard_active = ({1'b0, div_cnt_q} < (DIV_W + 1)'(GUARD_CYCLES));
    end else begin : g_no_guard
      assign guard_active = 1'b0;
    end
  endgenerate

  // Shadow capture: inputs only matter on a load strobe, so the display
  // never shows a half-updated word.
  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path can leave it holding its old value and infer a latch.
  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    if (load) begin
      digits_d = digits;
      dp_d     = dp;
      blank_d  = blank;
    end
  end

  // Refresh divider and digit index: the index advances when a slot ends.
  always_comb begin
    slot_end   = (div_cnt_q == LAST_DIV);
    frame_end  = slot_end && (scan_idx_q == LAST_IDX);
    div_cnt_d  = slot_end ? '0 : div_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (slot_end) begin
      scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // Output decode: dark during guard cycles or for dark digits; otherwise one
  // anode low and the glyph of the digit being scanned.
  always_comb begin
    an_d         = '1;
    seg_d        = 8'hFF;
    frame_done_d = frame_end;
    if (!guard_active && !blank_q[scan_idx_q] && !blink_dark[scan_idx_q]) begin
      an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
      seg_d = {~dp_q[scan_idx_q], glyph(digits_q[4*int'(scan_idx_q) +: 4])};
    end
  end

  // State and output registers; reset wins over a simultaneous load.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q     <= '1;
      dp_q         <= '0;
      blank_q      <= '1;
      div_cnt_q    <= '0;
      scan_idx_q   <= '0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      div_cnt_q    <= div_cnt_d;
      scan_idx_q   <= scan_idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seven_seg  = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed plus randomized stimulus for seven_seg_scan.
// The expected outputs come from a cycle-count model: the slot, digit, frame
// and blink phase are derived arithmetically from the number of cycles since
// reset, and the shadow contents follow the load strobe.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int R  = 4;
  localparam int G  = 1;
  localparam int BF = 2;

  // Common-anode glyph codes {g..a} for codes 0..15.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1000111, 7'b0000110,
    7'b1000001, 7'b1001000, 7'b0111111, 7'b1111111
  };

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp;
  logic [ND-1:0] blank;
  logic [ND-1:0] blink_mask;
  logic [7:0]    seven_seg;
  logic [ND-1:0] an;
  logic          frame_done;

  int n_vec  = 0;
  int n_fail = 0;

  // Model state.
  int            m_cyc   = 0;
  logic [4*ND-1:0] m_dig = '1;
  logic [ND-1:0] m_dp    = '0;
  logic [ND-1:0] m_blank = '1;
  logic [ND-1:0] m_bm    = '0;

  seven_seg_scan #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (R),
    .GUARD_CYCLES(G),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits    (digits),
    .dp        (dp),
    .blank     (blank),
    .blink_mask(blink_mask),
    .seven_seg (seven_seg),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, m_cyc, obs, exp);
    end
  endtask

  // One clock: predict the outputs of this edge from the pre-edge model
  // state, advance the model, then compare 1 time unit after the edge.
  task automatic tick();
    logic [ND-1:0] exp_an;
    logic [7:0]    exp_seg;
    logic          exp_fd;
    int            div;
    int            idx;
    int            ph;
    @(posedge clk);
    exp_an  = '1;
    exp_seg = 8'hFF;
    exp_fd  = 1'b0;
    if (rst) begin
      m_cyc   = 0;
      m_dig   = '1;
      m_dp    = '0;
      m_blank = '1;
      m_bm    = '0;
    end else begin
      div = m_cyc % R;
      idx = (m_cyc / R) % ND;
`ifdef SEVEN_SEG_BLINK_EN
      ph  = (m_cyc / (R * ND * BF)) % 2;
`else
      ph  = 0;
`endif
      if (div >= G && !m_blank[idx] && !(ph == 1 && m_bm[idx])) begin
        exp_an[idx] = 1'b0;
        exp_seg     = {~m_dp[idx], GLYPH[m_dig[4*idx +: 4]]};
      end
      exp_fd = ((m_cyc % (R * ND)) == (R * ND - 1));
      m_cyc++;
      if (load) begin
        m_dig   = digits;
        m_dp    = dp;
        m_blank = blank;
        m_bm    = blink_mask;
      end
    end
    #1;
    check("an", {4'b0000, an}, {4'b0000, exp_an});
    check("seven_seg", seven_seg, exp_seg);
    check("frame_done", {7'b0, frame_done}, {7'b0, exp_fd});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] b, input logic [3:0] m);
    digits     = d;
    dp         = p;
    blank      = b;
    blink_mask = m;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    digits     = '0;
    dp         = '0;
    blank      = '0;
    blink_mask = '0;

    // Reset held for three cycles, then idle with the reset shadow (all dark).
    run(3);
    rst = 1'b0;
    run(40);

    // "1234" with the decimal point on digit 1.
    do_load(16'h1234, 4'b0010, 4'b0000, 4'b0000);
    run(40);

    // Inputs change without a load: the display must not follow them.
    digits = 16'h9876;
    dp     = 4'b1111;
    blank  = 4'b1111;
    run(24);

    // Letter glyphs, then dashes with a blank code on digit 0.
    do_load(16'hABCD, 4'b0000, 4'b0000, 4'b0000);
    run(20);
    do_load(16'hEEEF, 4'b0000, 4'b0000, 4'b0000);
    run(20);

    // Reset and load in the same cycle: reset wins, nothing is captured.
    digits = 16'h5555;
    dp     = 4'b1111;
    blank  = 4'b0000;
    rst    = 1'b1;
    load   = 1'b1;
    tick();
    rst    = 1'b0;
    load   = 1'b0;
    run(24);

    // Blink mask on digit 0 across several blink half-periods.
    do_load(16'h1234, 4'b0000, 4'b0000, 4'b0001);
    run(140);

    // Randomized traffic: occasional loads and rare resets.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 7) == 0);
      digits     = 16'($urandom);
      dp         = 4'($urandom);
      blank      = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      blink_mask = 4'($urandom);
      tick();
    end
    rst  = 1'b0;
    load = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for an N-digit, common-anode 7-segment display. It generalises the single-digit glyph decoder to NUM_DIGITS digits.
- Captures a packed digit word, decimal points and per-digit blanks into a shadow register on a load strobe.
- Scans one digit per refresh slot, with an anode-off guard interval at the start of each slot to suppress ghosting.
- Sits between the game/score logic and the board's anode/cathode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= GUARD_CYCLES+1.
- GUARD_CYCLES, 2, cycles at the start of each slot during which all anodes are off; 0 disables the guard.
- BLINK_FRAMES, 64, full scan frames per blink half-period; used only with SEVEN_SEG_BLINK_EN.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- load, in, 1, single-cycle strobe; captures digits/dp/blank/blink_mask into the shadow register.
- digits, in, 4*NUM_DIGITS, packed glyph codes; digit i is bits [4i+3:4i]; digit 0 is rightmost.
- dp, in, NUM_DIGITS, decimal point enable per digit, 1 = lit.
- blank, in, NUM_DIGITS, 1 = digit fully dark regardless of glyph/dp.
- blink_mask, in, NUM_DIGITS, 1 = digit blinks (effective only with SEVEN_SEG_BLINK_EN).
- seven_seg, out, 8, active-low cathodes {dp,g,f,e,d,c,b,a}.
- an, out, NUM_DIGITS, active-low anodes; an[i] drives digit i.
- frame_done, out, 1, one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Reset, rst high at a clk edge:
  - shadow digits = all 4'hF, dp = 0, blank = all 1, blink_mask = 0.
  - div_cnt = 0, scan_idx = 0, blink phase = 0.
  - an = all 1s, seven_seg = 8'hFF, frame_done = 0.
  - rst has priority over load.
- Glyph table, 4-bit code -> seven_seg[6:0] (dp bit excluded):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000
  - 10 L: 1000111, 11 E: 0000110, 12 U: 1000001, 13 N: 1001000
  - 14 '-': 0111111, 15: 1111111 (blank)
  - seven_seg[7] = ~dp of the selected digit.
- Load: when load=1 at an edge, all four shadow fields update at that edge. Output reflects them from the next registered update. Inputs are ignored when load=0, so a mid-frame change cannot tear the display.
- Divider: div_cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and scan_idx advances, wrapping NUM_DIGITS-1 -> 0. scan_idx width = max(1, clog2(NUM_DIGITS)).
- frame_done is registered; it is 1 for exactly the one cycle following the edge at which scan_idx wraps to 0. With NUM_DIGITS=1 it pulses every slot.
- Outputs are registered and have one-cycle latency from div_cnt/scan_idx/shadow state.
- Digit i is dark when blank[i]=1, or when blink phase=1 and blink_mask[i]=1 (macro builds only). Dark means an = all 1s, seven_seg = 8'hFF.
- When div_cnt < GUARD_CYCLES: an = all 1s and seven_seg = 8'hFF.
- Otherwise, if the digit is not dark: an = one-hot-low at scan_idx, seven_seg = glyph of shadow digit scan_idx with dp applied.
- At most one anode is ever low. All anodes are high during reset and during guard cycles.

Optional Feature:
- Macro: SEVEN_SEG_BLINK_EN.
- Defined:
  - A frame counter 0..BLINK_FRAMES-1 advances on each frame wrap.
  - At its wrap the blink phase toggles.
  - While phase=1, digits with shadow blink_mask=1 are dark.
  - Phase and counter reset to 0.
- Undefined:
  - blink_mask is still a port but is ignored; no frame counter or phase register is built.
  - Behaviour is identical to the macro build with blink_mask=0.

Test Plan:
- Bench configuration: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, BLINK_FRAMES=2.
- Reset: hold rst 3 cycles, release -> an=4'b1111, seven_seg=8'hFF, frame_done=0 while rst high; afterwards all digits dark (blank=1111) with frame_done pulsing every 16 cycles.
- Load and scan: load digits=16'h1234, dp=4'b0010, blank=0 -> per slot, 1 guard cycle of an=1111, then 3 cycles of:
  - an=1110, seven_seg=8'b10011001 ('4')
  - an=1101, seven_seg=8'b00110000 ('3' with dp)
  - an=1011, seven_seg=8'b10100100 ('2')
  - an=0111, seven_seg=8'b11111001 ('1')
  - frame_done asserted the cycle after the wrap to digit 0.
- Glyphs: load digits=16'hABCD -> digit0 'N' 8'b11001000, digit1 'U' 8'b11000001, digit2 'E' 8'b10000110, digit3 'L' 8'b11000111; load 16'hEEEF -> digit0 dark, digits 1-3 show 8'b10111111.
- No tearing and priority: change digits without load mid-frame -> display unchanged; assert rst and load in the same cycle -> reset values, no capture.
- Blink, macro defined: blink_mask=4'b0001 -> digit 0 lit for 2 frames, dark for 2 frames, repeating; other digits always lit. Macro undefined: digit 0 always lit.
